ysyx_22050019_mem_arbiter: RTL and testbench

Two-requester memory arbiter for the ysyx_22050019 RV64 core. It shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). The LSU side is driven by the decoder's ram_re/ram_we/ram_wdata/mem width controls. The block sequences one outstanding transaction at a time through a request/response FSM with round-robin grant.

---
 rtl/ysyx_22050019_arb_pkg.sv | 19 +
 rtl/ysyx_22050019_rr_arb2.sv | 27 ++
 rtl/ysyx_22050019_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050019_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_arb_pkg
// Shared definitions for the IFU/LSU memory arbiter:
//   arb_state_e : request/response FSM encoding
//   OWN_IFU/LSU : owner / last-grant encoding (also the index into req/gnt)
// ---------------------------------------------------------------------------
package ysyx_22050019_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_rr_arb2
// Combinational two-way round-robin arbiter.
//   req[1:0] : request bits, index 0 = IFU, index 1 = LSU
//   last     : owner granted last time (OWN_IFU / OWN_LSU)
//   gnt[1:0] : one-hot grant, all-zero when nobody requests
// ---------------------------------------------------------------------------
module ysyx_22050019_rr_arb2
    import ysyx_22050019_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = (last == OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_22050019_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_mem_arbiter
// Shares the single data-memory port between the IFU and the LSU, one
// outstanding transaction at a time (IDLE -> REQ -> WAIT -> RESP).
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr         : IFU read request (valid/ready)
//   ifu_rsp_*/ifu_rdata        : IFU read response (valid/ready)
//   lsu_req_*/lsu_addr/we/...  : LSU load/store request (valid/ready)
//   lsu_rsp_*/lsu_rdata        : LSU load data or store ack (0 for stores)
//   mem_req_*/mem_addr/...     : latched request towards memory
//   mem_rsp_*/mem_rdata        : memory response
// ---------------------------------------------------------------------------
module ysyx_22050019_mem_arbiter
    import ysyx_22050019_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_we,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                owner_q;
    logic                last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          gnt;
    logic                grant_en;
    logic                win_lsu;
    logic                owner_rsp_ready;

    ysyx_22050019_rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    // Grants are only honoured in IDLE, so a RESP handshake and a new grant
    // can never share a cycle.
    assign grant_en        = (state_q == IDLE) && (gnt != 2'b00);
    assign win_lsu         = gnt[1];
    assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                ifu_req_ready = gnt[0];
                lsu_req_ready = gnt[1];
                if (grant_en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ifu_rsp_valid = (owner_q == OWN_IFU);
                lsu_rsp_valid = (owner_q == OWN_LSU);
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload, owner and round-robin history are captured on the grant.
    // Reset clears them so every address/data output reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else if (grant_en) begin
            owner_q      <= win_lsu ? OWN_LSU : OWN_IFU;
            last_grant_q <= win_lsu ? OWN_LSU : OWN_IFU;
            if (win_lsu) begin
                addr_q  <= lsu_addr;
                we_q    <= lsu_we;
                wdata_q <= lsu_wdata;
                wmask_q <= lsu_wmask;
            end else begin
                addr_q  <= ifu_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Store acknowledges carry zero data rather than whatever memory returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state_q == WAIT) && mem_rsp_valid) begin
            rdata_q <= ((owner_q == OWN_LSU) && we_q) ? '0 : mem_rdata;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign ifu_rdata = rdata_q;
    assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
module tb_ysyx_22050019_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [63:0] ifu_addr;
    logic        ifu_rsp_valid, ifu_rsp_ready;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [63:0] lsu_addr;
    logic        lsu_we;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_rsp_valid, lsu_rsp_ready;
    logic [63:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    ysyx_22050019_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_we        (lsu_we),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait transaction C0..C3; the caller has already raised the
    // request(s). Leaves the bench one tick into C4 (IDLE again).
    task automatic do_txn(input string nm, input logic exp_lsu,
                          input logic [63:0] e_addr, input logic e_we,
                          input logic [63:0] e_wdata, input logic [7:0] e_wmask,
                          input logic [63:0] m_rdata, input logic [63:0] e_rsp);
        // C0: grant
        @(negedge clk);
        chk({nm, "_c0_ifu_rdy"}, ifu_req_ready, !exp_lsu);
        chk({nm, "_c0_lsu_rdy"}, lsu_req_ready, exp_lsu);
        chk({nm, "_c0_mreq"},    mem_req_valid, 1'b0);
        tick();
        if (exp_lsu) lsu_req_valid = 1'b0;
        else         ifu_req_valid = 1'b0;
        // C1: request to memory
        @(negedge clk);
        chk({nm, "_c1_mreq"},  mem_req_valid, 1'b1);
        chk({nm, "_c1_addr"},  mem_addr, e_addr);
        chk({nm, "_c1_we"},    mem_we, e_we);
        chk({nm, "_c1_wdata"}, mem_wdata, e_wdata);
        chk({nm, "_c1_wmask"}, mem_wmask, e_wmask);
        chk({nm, "_c1_rdys"},  {ifu_req_ready, lsu_req_ready}, 2'b00);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rdata     = m_rdata;
        // C2: memory response
        @(negedge clk);
        chk({nm, "_c2_mrsp_rdy"}, mem_rsp_ready, 1'b1);
        chk({nm, "_c2_rsps"},     {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        // C3: response to owner
        @(negedge clk);
        chk({nm, "_c3_ifu_rsp"}, ifu_rsp_valid, !exp_lsu);
        chk({nm, "_c3_lsu_rsp"}, lsu_rsp_valid, exp_lsu);
        chk({nm, "_c3_rdata"},   exp_lsu ? lsu_rdata : ifu_rdata, e_rsp);
        chk({nm, "_c3_rdys"},    {ifu_req_ready, lsu_req_ready}, 2'b00);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_we = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0; lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_mreq",  mem_req_valid, 1'b0);
        chk("rst_mrdy",  mem_rsp_ready, 1'b0);
        chk("rst_rsps",  {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready}, 4'h0);
        chk("rst_addr",  mem_addr, 64'h0);
        chk("rst_pay",   {mem_we, mem_wmask}, 9'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 64'h0);
        tick();
        rst_n = 1'b1;

        // Spurious memory response in IDLE
        mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        chk("spur_mrdy", mem_rsp_ready, 1'b0);
        chk("spur_rsps", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("spur_after", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        tick();

        // Single IFU read
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
        do_txn("ifu_rd", 1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00,
               64'h0000_0013_0000_0297, 64'h0000_0013_0000_0297);
        @(negedge clk);
        chk("ifu_rd_c4", {ifu_rsp_valid, mem_req_valid}, 2'b00);
        tick();

        // LSU store: store ack carries zero data
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_1008; lsu_we = 1'b1;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wmask = 8'hF0;
        do_txn("lsu_st", 1'b1, 64'h8000_1008, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0,
               64'h1111_2222_3333_4444, 64'h0);
        lsu_we = 1'b0; lsu_wdata = '0; lsu_wmask = '0;

        // Tie from reset: LSU, IFU, LSU, IFU
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3000;
        do_txn("tie1", 1'b1, 64'h8000_3000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_0A01, 64'h0000_0000_0000_0A01);
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3008; lsu_we = 1'b1;
        lsu_wdata = 64'h0123_4567_89AB_CDEF; lsu_wmask = 8'h00;
        do_txn("tie2", 1'b0, 64'h8000_0010, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_0B02, 64'h0000_0000_0000_0B02);
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0014;
        // zero-mask store forwarded unchanged
        do_txn("tie3", 1'b1, 64'h8000_3008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0000_0000_0000_0C03, 64'h0);
        lsu_we = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_3010;
        do_txn("tie4", 1'b0, 64'h8000_0014, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_0D04, 64'h0000_0000_0000_0D04);
        do_txn("tie5", 1'b1, 64'h8000_3010, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_0E05, 64'h0000_0000_0000_0E05);

        // Back-pressure: last grant was LSU so IFU wins this tie
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_2000;
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("bp_c0_ifu_rdy", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mem_req_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_req%0d_v", i),    mem_req_valid, 1'b1);
            chk($sformatf("bp_req%0d_addr", i), mem_addr, 64'h8000_0040);
            chk($sformatf("bp_req%0d_gnt", i),  lsu_req_ready, 1'b0);
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 64'hAAAA_5555_AAAA_5555;
        ifu_rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_wait_mrdy", mem_rsp_ready, 1'b1);
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ifu_rsp_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_rsp%0d_v", i),    ifu_rsp_valid, 1'b1);
            chk($sformatf("bp_rsp%0d_data", i), ifu_rdata, 64'hAAAA_5555_AAAA_5555);
            chk($sformatf("bp_rsp%0d_oth", i),  {lsu_rsp_valid, lsu_req_ready}, 2'b00);
            tick();
        end
        do_txn("bp_lsu", 1'b1, 64'h8000_2000, 1'b0, 64'h0, 8'h00,
               64'h0000_5555_0000_5555, 64'h0000_5555_0000_5555);

        // Reset in the middle of WAIT
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0100;
        @(negedge clk);
        chk("rw_c0_ifu_rdy", ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("rw_c1_mreq", mem_req_valid, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ctl",  {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 4'h0);
        chk("rw_rst_addr", mem_addr, 64'h0);
        tick();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        chk("rw_stray_mrdy", mem_rsp_ready, 1'b0);
        tick();
        mem_rsp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("rw_stray_rsps", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
        chk("rw_stray_data", ifu_rdata, 64'h0);
        tick();
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0200;
        lsu_req_valid = 1'b1; lsu_addr = 64'h8000_4000;
        do_txn("rw_tie1", 1'b1, 64'h8000_4000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234);
        do_txn("rw_tie2", 1'b0, 64'h8000_0200, 1'b0, 64'h0, 8'h00, 64'h0000_0000_0000_5678, 64'h0000_0000_0000_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
